xy_stim_gen: RTL

//  Driver side of the two-bit x/y input interface of the small Mealy/Moore FSM exercises.

---
 rtl/xy_stim_if.sv | 36 +++
 rtl/xy_stim_gen.sv | 135 +++++++++++++
 2 files changed

// File: rtl/xy_stim_if.sv
// Vector load / playback bundle between a sequence source (master) and
// xy_stim_gen (slave).
//
// Handshake: a vector {in_x, in_y, in_hold} transfers on a rising edge where
// in_valid && in_ready are both 1. The master holds in_valid and the payload
// stable until that edge. in_ready depends only on registered FIFO occupancy,
// never on in_valid, so there is no combinational loop back to the source.
interface xy_stim_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic             in_x;
    logic             in_y;
    logic [CNT_W-1:0] in_hold;
    logic             run;
    logic             x;
    logic             y;
    logic             busy;
    logic             done;
    logic [LVL_W-1:0] level;
    logic             dbg_state;   // 0 = IDLE, 1 = PLAY

    modport master (
        output in_valid, in_x, in_y, in_hold, run,
        input  in_ready, x, y, busy, done, level, dbg_state
    );

    modport slave (
        input  in_valid, in_x, in_y, in_hold, run,
        output in_ready, x, y, busy, done, level, dbg_state
    );
endinterface

// File: rtl/xy_stim_gen.sv
// Buffers (x, y, hold) vectors in a small FIFO and plays them out on
// registered x/y drives, each vector lasting hold+1 cycles with no gap
// between consecutive vectors while run stays high.
module xy_stim_gen #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic      clk,
    input  logic      rst_b,
    xy_stim_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = CNT_W + 2;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             x_q, x_d;
    logic             y_q, y_d;
    logic             done_q, done_d;
    logic             can_push;
    logic             push;
    logic             pop;
    logic             has_entry;
    logic [ENT_W-1:0] head;

    // Acceptance and pop eligibility both look at registered occupancy only,
    // so a same-cycle pop never frees space for a push and an entry pushed
    // this cycle can never be popped this cycle.
    assign can_push  = (level_q != FULL_LVL);
    assign push      = bus.in_valid && can_push;
    assign has_entry = (level_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_x, bus.in_y, bus.in_hold};
        end
    end

    // Next state, playback counter, drive values and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run && has_entry) begin
                    pop     = 1'b1;
                    x_d     = head[ENT_W-1];
                    y_d     = head[ENT_W-2];
                    rem_d   = head[CNT_W-1:0];
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - CNT_W'(1);
                end else if (!has_entry) begin
                    // Drained: report completion once, keep last drive.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (bus.run) begin
                    // Back-to-back vector, no idle cycle in between.
                    pop   = 1'b1;
                    x_d   = head[ENT_W-1];
                    y_d   = head[ENT_W-2];
                    rem_d = head[CNT_W-1:0];
                end else begin
                    // Paused at a vector boundary with entries still queued.
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy update; simultaneous push and pop cancel.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // State, pointer and output registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rem_q    <= '0;
            x_q      <= 1'b0;
            y_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            rem_q   <= rem_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign bus.in_ready  = can_push;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.busy      = (state_q == S_PLAY);
    assign bus.done      = done_q;
    assign bus.level     = level_q;
    assign bus.dbg_state = state_q;
endmodule
